// File: rtl/tlul_host_arb_pkg.sv
// Shared types and helpers for the N-host to 1-device TL-UL arbiter.
package tlul_host_arb_pkg;

    localparam int unsigned MaxHostsSupported = 8;
    localparam int unsigned SrcW = 8;

    typedef logic [2:0] host_idx_t;

    typedef struct packed {
        logic            a_valid;
        logic [2:0]      a_opcode;
        logic [2:0]      a_param;
        logic [1:0]      a_size;
        logic [SrcW-1:0] a_source;
        logic [31:0]     a_address;
        logic [3:0]      a_mask;
        logic [31:0]     a_data;
        logic            d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic            d_valid;
        logic [2:0]      d_opcode;
        logic [2:0]      d_param;
        logic [1:0]      d_size;
        logic [SrcW-1:0] d_source;
        logic            d_sink;
        logic [31:0]     d_data;
        logic            d_error;
        logic            a_ready;
    } tl_d2h_t;

    function automatic int unsigned host_id_w(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Host index occupies the low bits; host source bits shifted out are dropped.
    function automatic logic [SrcW-1:0] tag_source(logic [SrcW-1:0] src, host_idx_t idx,
                                                   int unsigned idw);
        return (src << idw) | SrcW'(idx);
    endfunction

    function automatic logic [SrcW-1:0] untag_source(logic [SrcW-1:0] src, int unsigned idw);
        return src >> idw;
    endfunction

endpackage

// File: rtl/tlul_rr_arb.sv
// Round-robin arbiter with pointer advanced on the update strobe.
// TLUL_HOST_ARB_FIXED_PRIO_EN: pointer removed, lowest requesting index wins.
module tlul_rr_arb
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         update_i,
    output logic [N-1:0] gnt_o,
    output host_idx_t    idx_o
);

`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = clk_i ^ rst_i ^ update_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = host_idx_t'(i);
            end
        end
    end
`else
    host_idx_t ptr_q, ptr_d;
    logic      found;

    // Search above the pointer first, then wrap to the lower indices.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i > 32'(ptr_q))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = host_idx_t'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i <= 32'(ptr_q))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = host_idx_t'(i);
            end
        end
        ptr_d = update_i ? idx_o : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/tlul_host_arb.sv
// N-host to 1-device TL-UL arbiter: zero-latency datapath, grant lock, credit-limited A channel.
// Build option TLUL_HOST_ARB_FIXED_PRIO_EN selects fixed priority (host 0 highest).
module tlul_host_arb
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned NumHosts       = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned HostIdW        = host_id_w(NumHosts)
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic    busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if (NumHosts < 2 || NumHosts > MaxHostsSupported) begin : g_bad_num_hosts
        $error("NumHosts out of range");
    end

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                lock_q, lock_d;
    host_idx_t           lock_idx_q, lock_idx_d;
    logic [NumHosts-1:0] req, gnt;
    host_idx_t           gnt_idx;
    tl_h2d_t             a_sel;
    logic                full, a_hs, d_hs, d_ready_c;
    logic [HostIdW-1:0]  d_idx;

    // A held request masks all other hosts so the grant cannot move.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            req[i] = lock_q ? (lock_idx_q == host_idx_t'(i)) : tl_h_i[i].a_valid;
        end
    end

    tlul_rr_arb #(.N(NumHosts)) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req),
        .update_i (a_hs),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx)
    );

    always_comb begin
        a_sel = '0;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            if (gnt[i]) a_sel = tl_h_i[i];
        end
        full            = (cnt_q == CntW'(MaxOutstanding));
        tl_d_o          = a_sel;
        tl_d_o.a_source = tag_source(a_sel.a_source, gnt_idx, HostIdW);
        tl_d_o.a_valid  = a_sel.a_valid & ~full & ~rst_i;

        // Responses to a nonexistent host are sunk here.
        d_idx     = tl_d_i.d_source[HostIdW-1:0];
        d_ready_c = 1'b1;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            if (32'(d_idx) == i) d_ready_c = tl_h_i[i].d_ready;
        end
        tl_d_o.d_ready = d_ready_c & ~rst_i;

        for (int unsigned i = 0; i < NumHosts; i++) begin
            tl_h_o[i]          = tl_d_i;
            tl_h_o[i].d_source = untag_source(tl_d_i.d_source, HostIdW);
            tl_h_o[i].d_valid  = tl_d_i.d_valid & (32'(d_idx) == i) & ~rst_i;
            tl_h_o[i].a_ready  = gnt[i] & tl_d_i.a_ready & ~full & ~rst_i;
        end

        a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
        d_hs = tl_d_i.d_valid & tl_d_o.d_ready;
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        cnt_d      = cnt_q;
        if (tl_d_o.a_valid) begin
            lock_d     = ~tl_d_i.a_ready;
            lock_idx_d = gnt_idx;
        end
        if (a_hs && !d_hs) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!a_hs && d_hs) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign busy_o = (cnt_q != '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(tl_d_o.a_valid && ((a_sel.a_source >> (SrcW - HostIdW)) != '0)))
            else $warning("host a_source upper bits nonzero, truncated");
            assert (!(tl_d_i.d_valid && (32'(d_idx) >= NumHosts)))
            else $warning("d_source host index %0d out of range, response dropped", d_idx);
            assert (!(d_hs && !a_hs && (cnt_q == '0)))
            else $error("outstanding counter underflow");
        end
    end
`endif

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb with a per-cycle behavioural model check.
module tb_tlul_host_arb;
    import tlul_host_arb_pkg::*;

    localparam int N    = 3;
    localparam int MAXO = 4;
    localparam int IDW  = 2;

    logic    clk;
    logic    rst;
    tl_h2d_t h_i [N];
    tl_d2h_t h_o [N];
    tl_h2d_t d_o;
    tl_d2h_t d_i;
    logic    busy;

    int n_checks = 0;
    int n_fail   = 0;

    int m_last = 0, m_lock = -1, m_out = 0;
    int nx_last = 0, nx_lock = -1, nx_out = 0;

    int gs [6];
    int exp_rr [6];

    tlul_host_arb #(.NumHosts(N), .MaxOutstanding(MAXO)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_h_i (h_i),
        .tl_h_o (h_o),
        .tl_d_o (d_o),
        .tl_d_i (d_i),
        .busy_o (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: grant goes to the held host, else the next requester after the last one served.
    always @(negedge clk) begin : model
        int g;
        int hh;
        bit full, exp_av, exp_dr, ahs, dhs;
        if (rst) begin
            chk("rst_dev_a_valid", 32'(d_o.a_valid), 0);
            chk("rst_dev_d_ready", 32'(d_o.d_ready), 0);
            chk("rst_busy", 32'(busy), 0);
            for (int i = 0; i < N; i++) begin
                chk("rst_host_a_ready", 32'(h_o[i].a_ready), 0);
                chk("rst_host_d_valid", 32'(h_o[i].d_valid), 0);
            end
            nx_last = 0; nx_lock = -1; nx_out = 0;
        end else begin
            full = (m_out == MAXO);
            g = -1;
            if (m_lock >= 0) begin
                g = m_lock;
            end else begin
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
                for (int c = N - 1; c >= 0; c--) if (h_i[c].a_valid) g = c;
`else
                for (int k = N; k >= 1; k--) if (h_i[(m_last + k) % N].a_valid) g = (m_last + k) % N;
`endif
            end
            exp_av = 1'b0;
            if (g >= 0) exp_av = h_i[g].a_valid && !full;
            chk("dev_a_valid", 32'(d_o.a_valid), 32'(exp_av));
            if (exp_av) begin
                chk("dev_a_source", 32'(d_o.a_source), ((int'(h_i[g].a_source) << IDW) | g) & 32'hff);
                chk("dev_a_address", d_o.a_address, h_i[g].a_address);
            end
            for (int i = 0; i < N; i++)
                chk("host_a_ready", 32'(h_o[i].a_ready), 32'((i == g) && d_i.a_ready && !full));

            hh = int'(d_i.d_source) % (1 << IDW);
            exp_dr = 1'b1;
            if (hh < N) exp_dr = h_i[hh].d_ready;
            chk("dev_d_ready", 32'(d_o.d_ready), 32'(exp_dr));
            for (int i = 0; i < N; i++)
                chk("host_d_valid", 32'(h_o[i].d_valid), 32'(d_i.d_valid && (i == hh)));
            if (d_i.d_valid && hh < N)
                chk("host_d_source", 32'(h_o[hh].d_source), int'(d_i.d_source) >> IDW);
            chk("busy", 32'(busy), 32'(m_out != 0));

            ahs = exp_av && d_i.a_ready;
            dhs = d_i.d_valid && exp_dr;
            nx_out  = m_out + (ahs ? 1 : 0) - (dhs ? 1 : 0);
            nx_last = ahs ? g : m_last;
            nx_lock = ahs ? -1 : (exp_av ? g : m_lock);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = 0; m_lock = -1; m_out = 0;
        end else begin
            m_last = nx_last; m_lock = nx_lock; m_out = nx_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            h_i[i].a_valid = 1'b0;
            h_i[i].d_ready = 1'b0;
        end
        d_i.d_valid = 1'b0;
    endtask

    initial begin
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0, 0};
`else
        exp_rr = '{1, 2, 0, 1, 2, 0};
`endif
        rst = 1'b1;
        d_i = '0;
        for (int i = 0; i < N; i++) begin
            h_i[i] = '0;
            h_i[i].a_opcode  = 3'd4;
            h_i[i].a_address = 32'h1000 + 32'(i) * 32'h100;
            h_i[i].a_mask    = 4'hf;
        end
        h_i[0].a_source = 8'h0a;
        h_i[1].a_source = 8'h05;
        h_i[2].a_source = 8'h07;
        tick();
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dev_a_valid", 32'(d_o.a_valid), 0);
        tick();
        rst = 1'b0;
        d_i.a_ready = 1'b1;

        // Single host access on host1.
        h_i[1].a_valid = 1'b1;
        #1;
        chk("single_a_source", 32'(d_o.a_source), 32'h15);
        chk("single_a_ready", 32'(h_o[1].a_ready), 1);
        tick();
        h_i[1].a_valid = 1'b0;
        #1;
        chk("single_busy", 32'(busy), 1);
        d_i.d_valid = 1'b1;
        d_i.d_source = 8'h15;
        h_i[1].d_ready = 1'b1;
        #1;
        chk("single_d_valid", 32'(h_o[1].d_valid), 1);
        chk("single_d_source", 32'(h_o[1].d_source), 32'h05);
        chk("single_h0_d_valid", 32'(h_o[0].d_valid), 0);
        chk("single_h2_d_valid", 32'(h_o[2].d_valid), 0);
        tick();
        idle_all();

        // Round-robin fairness with all hosts requesting.
        do_reset();
        for (int i = 0; i < N; i++) begin
            h_i[i].a_valid = 1'b1;
            h_i[i].d_ready = 1'b1;
        end
        d_i.d_source = 8'h00;
        for (int c = 0; c < 6; c++) begin
            #1;
            gs[c] = int'(d_o.a_source[1:0]);
            tick();
            d_i.d_valid = 1'b1;
        end
        for (int i = 0; i < N; i++) h_i[i].a_valid = 1'b0;
        tick();
        idle_all();
        for (int c = 0; c < 6; c++) chk("rr_grant_seq", 32'(gs[c]), 32'(exp_rr[c]));

        // Grant lock: host2 stalled, host0 arrives mid-request.
        do_reset();
        d_i.a_ready = 1'b0;
        h_i[2].a_valid = 1'b1;
        tick();
        h_i[0].a_valid = 1'b1;
        #1;
        chk("lock_addr_c1", d_o.a_address, 32'h1200);
        chk("lock_src_c1", 32'(d_o.a_source), 32'h1e);
        tick();
        #1;
        chk("lock_addr_c2", d_o.a_address, 32'h1200);
        tick();
        d_i.a_ready = 1'b1;
        #1;
        chk("lock_addr_c3", d_o.a_address, 32'h1200);
        tick();
        h_i[2].a_valid = 1'b0;
        #1;
        chk("lock_next_grant", 32'(d_o.a_source), 32'h28);
        tick();
        h_i[0].a_valid = 1'b0;

        // Reset with two outstanding and a held request.
        d_i.a_ready = 1'b0;
        h_i[1].a_valid = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_dev_a_valid", 32'(d_o.a_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_d_ready", 32'(d_o.d_ready), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) h_i[i].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        #1;
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
        chk("postrst_grant", 32'(d_o.a_source[1:0]), 0);
`else
        chk("postrst_grant", 32'(d_o.a_source[1:0]), 1);
`endif
        tick();
        for (int i = 0; i < N; i++) h_i[i].a_valid = 1'b0;
        d_i.d_valid = 1'b1;
        d_i.d_source = 8'h15;
        h_i[1].d_ready = 1'b1;
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
        d_i.d_source = 8'h28;
        h_i[0].d_ready = 1'b1;
`endif
        tick();
        idle_all();

        // Credit limit.
        h_i[0].a_valid = 1'b1;
        repeat (4) tick();
        #1;
        chk("credit_a_ready", 32'(h_o[0].a_ready), 0);
        chk("credit_dev_a_valid", 32'(d_o.a_valid), 0);
        chk("credit_busy", 32'(busy), 1);
        d_i.d_valid = 1'b1;
        d_i.d_source = 8'h28;
        h_i[0].d_ready = 1'b1;
        tick();
        #1;
        chk("credit_reopen", 32'(d_o.a_valid), 1);
        tick();
        h_i[0].a_valid = 1'b0;
        tick();
        tick();
        chk("credit_busy_one_left", 32'(busy), 1);
        tick();
        d_i.d_valid = 1'b0;
        #1;
        chk("credit_drained", 32'(busy), 0);
        idle_all();

        // Illegal D source index.
        h_i[2].a_valid = 1'b1;
        tick();
        h_i[2].a_valid = 1'b0;
        d_i.d_valid = 1'b1;
        d_i.d_source = 8'h03;
        #1;
        chk("illegal_d_ready", 32'(d_o.d_ready), 1);
        for (int i = 0; i < N; i++) chk("illegal_d_valid", 32'(h_o[i].d_valid), 0);
        tick();
        d_i.d_valid = 1'b0;
        #1;
        chk("illegal_count_dec", 32'(busy), 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
